// File: rtl/sm2_naf_pkg.sv
// Shared types and constants for the SM2 wNAF scalar recoder.
package sm2_naf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_RUN  = 3'b010,
    ST_FIN  = 3'b100
  } state_e;

  localparam int unsigned DIG_ZERO = 32'd0;
  localparam int unsigned DIG_ONE  = 32'd1;

  // Largest digit magnitude for window w: 2^(w-1) - 1.
  function automatic int unsigned dig_limit(input int unsigned w);
    return (32'd1 << (w - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/wnaf_digit.sv
// One wNAF step: signed digit for the current scalar and the scalar left after removing it.
module wnaf_digit
  import sm2_naf_pkg::*;
#(
  parameter int KW = 256,
  parameter int W  = 4
) (
  input  logic [KW:0]  k_cur_i,
  output logic [W-1:0] d_o,
  output logic [KW:0]  k_next_o
);

  localparam logic [W-1:0] LIM = W'(dig_limit(W));

  logic [W-1:0] r_s;
  logic [W-1:0] mag_s;

  assign r_s   = k_cur_i[W-1:0];
  assign mag_s = ~r_s + {{(W-1){1'b0}}, 1'b1};

  // Negative digits share the bit pattern of r, so only the k update differs.
  always_comb begin
    d_o      = W'(DIG_ZERO);
    k_next_o = k_cur_i >> 1'b1;
    if (!k_cur_i[0]) begin
      d_o      = W'(DIG_ZERO);
      k_next_o = k_cur_i >> 1'b1;
    end else if (r_s <= LIM) begin
      d_o      = r_s;
      k_next_o = (k_cur_i - (KW+1)'(r_s)) >> 1'b1;
    end else begin
      d_o      = r_s;
      k_next_o = (k_cur_i + (KW+1)'(mag_s)) >> 1'b1;
    end
  end

endmodule

// File: rtl/wnaf_encoder.sv
// Streaming width-W NAF recoder: emits signed digits LSB-first over valid/ready.
module wnaf_encoder
  import sm2_naf_pkg::*;
#(
  parameter int KW = 256,
  parameter int W  = 4,
  parameter int LW = $clog2(KW + 2)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [KW-1:0] k,
  output logic          busy,
  output logic          dig_valid,
  input  logic          dig_ready,
  output logic [W-1:0]  dig_data,
  output logic          dig_last,
  output logic          done,
  output logic [LW-1:0] dlen
);

  generate
    if (W < 2 || W > 6) begin : g_bad_window
      $error("wnaf_encoder: W must be in 2..6");
    end
  endgenerate

  state_e        state_q;
  logic [KW:0]   k_cur_q;
  logic [KW:0]   k_cur_d;
  logic [W-1:0]  d_s;
  logic          last_s;
  logic [LW-1:0] cnt_q;
  logic [LW-1:0] dlen_q;
  logic          busy_q;
  logic          valid_q;
  logic          done_q;

  wnaf_digit #(.KW(KW), .W(W)) u_digit (
    .k_cur_i  (k_cur_q),
    .d_o      (d_s),
    .k_next_o (k_cur_d)
  );

  assign last_s = (k_cur_d == '0);

  // Control FSM; k_cur only advances on a handshake so a stalled digit stays put.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      k_cur_q <= '0;
      cnt_q   <= '0;
      dlen_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            k_cur_q <= {1'b0, k};
            cnt_q   <= '0;
            dlen_q  <= '0;
            busy_q  <= 1'b1;
            if (k != '0) begin
              state_q <= ST_RUN;
              valid_q <= 1'b1;
            end else begin
              state_q <= ST_FIN;
              done_q  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (valid_q && dig_ready) begin
            k_cur_q <= k_cur_d;
            cnt_q   <= cnt_q + LW'(DIG_ONE);
            if (last_s) begin
              state_q <= ST_FIN;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
              dlen_q  <= cnt_q + LW'(DIG_ONE);
            end
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign dig_valid = valid_q;
  assign dig_data  = valid_q ? d_s : W'(DIG_ZERO);
  assign dig_last  = valid_q && last_s;
  assign done      = done_q;
  assign dlen      = dlen_q;

endmodule
